// File: rtl/posit_pkg.sv
// Shared types, widths and helpers for the posit multiplier core.
package posit_pkg;

  localparam int N  = 8;           // posit word width
  localparam int ES = 3;           // exponent field width

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int RS = log2_ceil(N);  // regime value width minus 1
  localparam int MW = N - ES + 3;    // mantissa width, hidden bit at MSB
  localparam int SW = RS + ES + 2;   // signed product scale width
  localparam int PW = 2 * MW;        // full product mantissa width

  // Fields of one operand as delivered by the extraction stage.
  typedef struct packed {
    logic                 sign;
    logic signed [RS:0]   regime;
    logic [ES-1:0]        exponent;
    logic [MW-1:0]        mantissa;
    logic                 zero;
    logic                 nar;
  } operand_t;

  // Stage-1 contents: combined sign/scale/flags plus both mantissas.
  typedef struct packed {
    logic                 sign;
    logic signed [SW-1:0] scale;
    logic [MW-1:0]        mant_a;
    logic [MW-1:0]        mant_b;
    logic                 zero;
    logic                 nar;
  } s1_t;

  // Product before (stage 2) and after (stage 3) normalisation.
  typedef struct packed {
    logic                 sign;
    logic signed [SW-1:0] scale;
    logic [PW-1:0]        mantissa;
    logic                 zero;
    logic                 nar;
  } product_t;

  // regime*2^ES + exponent is just {regime, exponent} because the exponent
  // never reaches 2^ES; sign-extend that to the scale width.
  function automatic logic signed [SW-1:0] scale_of(input logic signed [RS:0] regime,
                                                    input logic [ES-1:0]      exponent);
    logic signed [RS+ES:0] joined;
    joined = {regime, exponent};
    return {{(SW-RS-ES-1){joined[RS+ES]}}, joined};
  endfunction

endpackage

// File: rtl/posit_mult_core_if.sv
// Operand/result handshake bundle for posit_mult_core.
interface posit_mult_core_if;
  import posit_pkg::*;

  logic                 InValid;
  logic                 InReady;
  logic                 ASign;
  logic                 BSign;
  logic signed [RS:0]   ARegime;
  logic signed [RS:0]   BRegime;
  logic [ES-1:0]        AExponent;
  logic [ES-1:0]        BExponent;
  logic [MW-1:0]        AMantissa;
  logic [MW-1:0]        BMantissa;
  logic                 AZero;
  logic                 BZero;
  logic                 ANaR;
  logic                 BNaR;
  logic                 OutValid;
  logic                 OutReady;
  logic                 Sign;
  logic signed [SW-1:0] Scale;
  logic [PW-1:0]        Mantissa;
  logic                 Zero;
  logic                 NaR;

  // Core side.
  modport slave (
    input  InValid, ASign, BSign, ARegime, BRegime, AExponent, BExponent,
           AMantissa, BMantissa, AZero, BZero, ANaR, BNaR, OutReady,
    output InReady, OutValid, Sign, Scale, Mantissa, Zero, NaR
  );

  // Producer/consumer side.
  modport master (
    output InValid, ASign, BSign, ARegime, BRegime, AExponent, BExponent,
           AMantissa, BMantissa, AZero, BZero, ANaR, BNaR, OutReady,
    input  InReady, OutValid, Sign, Scale, Mantissa, Zero, NaR
  );
endinterface

// File: rtl/posit_mult_normalise.sv
// Combinational stage-3 logic: one-bit normalisation of the raw product and
// forcing of zero/NaR results to their canonical all-zero payload.
module posit_mult_normalise
  import posit_pkg::*;
(
  input  product_t raw_i,
  output product_t res_o
);

  // Normalise the product or replace it with a special-value result.
  always_comb begin
    // NOTE: res_o gets a full default before any branch so every path drives it and no latch is inferred.
    res_o = raw_i;
    if (raw_i.nar) begin
      res_o     = '0;
      res_o.nar = 1'b1;
    end else if (raw_i.zero) begin
      res_o      = '0;
      res_o.zero = 1'b1;
    end else if (raw_i.mantissa[PW-1]) begin
      // Product of two [1,2) mantissas reached [2,4): bump the scale.
      res_o.scale = raw_i.scale + SW'(1);
    end else begin
      res_o.mantissa = {raw_i.mantissa[PW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/posit_mult_core.sv
// Three-stage posit multiplier core: S1 combines signs/scales/flags, S2 forms
// the mantissa product, S3 registers the normalised result. Each stage
// refills whenever it is empty or drains, so bubbles collapse.
module posit_mult_core
  import posit_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  posit_mult_core_if.slave  bus
);

  logic     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t      s1_q, s1_d;
  product_t s2_q, s2_d, s3_q, s3_d;
  product_t norm;
  logic     load1, load2, load3;
  operand_t op_a, op_b;

  assign op_a = '{sign: bus.ASign, regime: bus.ARegime, exponent: bus.AExponent,
                  mantissa: bus.AMantissa, zero: bus.AZero, nar: bus.ANaR};
  assign op_b = '{sign: bus.BSign, regime: bus.BRegime, exponent: bus.BExponent,
                  mantissa: bus.BMantissa, zero: bus.BZero, nar: bus.BNaR};

  // A stage loads when empty or when the stage after it loads; the chain
  // makes InReady combinational from OutReady.
  assign load3       = !v3_q || bus.OutReady;
  assign load2       = !v2_q || load3;
  assign load1       = !v1_q || load2;
  assign bus.InReady = load1;

  posit_mult_normalise u_normalise (
    .raw_i (s2_q),
    .res_o (norm)
  );

  // Next-state for valid bits and stage data; data only moves with a valid entry.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;

    if (load1) v1_d = bus.InValid;
    if (load1 && bus.InValid) begin
      s1_d.sign   = op_a.sign ^ op_b.sign;
      s1_d.scale  = scale_of(op_a.regime, op_a.exponent) + scale_of(op_b.regime, op_b.exponent);
      s1_d.mant_a = op_a.mantissa;
      s1_d.mant_b = op_b.mantissa;
      s1_d.nar    = op_a.nar | op_b.nar;
      s1_d.zero   = (op_a.zero | op_b.zero) & ~(op_a.nar | op_b.nar);
    end

    if (load2) v2_d = v1_q;
    if (load2 && v1_q) begin
      s2_d.sign     = s1_q.sign;
      s2_d.scale    = s1_q.scale;
      s2_d.mantissa = PW'(s1_q.mant_a) * PW'(s1_q.mant_b);
      s2_d.zero     = s1_q.zero;
      s2_d.nar      = s1_q.nar;
    end

    if (load3) v3_d = v2_q;
    if (load3 && v2_q) s3_d = norm;
  end

  // Pipeline registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: data registers are reset along with the valid bits because the result outputs must read zero out of reset.
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of the stage before it.
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.OutValid = v3_q;
  assign bus.Sign     = s3_q.sign;
  assign bus.Scale    = s3_q.scale;
  assign bus.Mantissa = s3_q.mantissa;
  assign bus.Zero     = s3_q.zero;
  assign bus.NaR      = s3_q.nar;

endmodule
